// File: rtl/fc_layer_sched_pkg.sv
// Shared constants for the FC layer scheduler and its dot-product datapath.
// State encoding and window lane geometry live here so the conv path can reuse them.
package fc_layer_sched_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_WAIT  = 3'd1;
  localparam state_t S_MAC   = 3'd2;
  localparam state_t S_DRAIN = 3'd3;
  localparam state_t S_OUT   = 3'd4;

  localparam int LANES  = 9;
  localparam int LANE_W = 8;
  localparam int WIN_W  = 72;
  localparam int PROD_W = 16;
  localparam int DOT_W  = 20;
  localparam int IDX_W  = 4;

endpackage

// File: rtl/fc_dot9.sv
// Combinational signed 9-lane 8x8 dot product; lane i sits at bits [71-8i -: 8].
module fc_dot9
  import fc_layer_sched_pkg::*;
(
  input  logic        [WIN_W-1:0] i_a,
  input  logic        [WIN_W-1:0] i_b,
  output logic signed [DOT_W-1:0] o_dot
);

  logic signed [PROD_W-1:0] w_prod [LANES];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign w_prod[gi] = $signed(i_a[WIN_W-1-LANE_W*gi -: LANE_W]) *
                        $signed(i_b[WIN_W-1-LANE_W*gi -: LANE_W]);
  end

  always_comb begin
    o_dot = '0;
    for (int i = 0; i < LANES; i++) begin
      o_dot = o_dot + {{(DOT_W-PROD_W){w_prod[i][PROD_W-1]}}, w_prod[i]};
    end
  end

endmodule

// File: rtl/fc_layer_sched.sv
// Fully-connected layer sequencer: accumulates NUM_WIN windows against a weight ROM,
// streams NUM_OUT scores over a valid/ready port, then pulses the argmax class.
module fc_layer_sched
  import fc_layer_sched_pkg::*;
#(
  parameter int NUM_OUT = 10,
  parameter int NUM_WIN = 16,
  parameter int ACC_W   = 24,
  parameter int ADDR_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     fc_ready,
  input  logic        [WIN_W-1:0]  fc_data,
  output logic                     w_rd,
  output logic        [ADDR_W-1:0] w_addr,
  input  logic        [WIN_W-1:0]  w_data,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic        [IDX_W-1:0]  res_idx,
  output logic signed [ACC_W-1:0]  res_data,
  output logic                     class_valid,
  output logic        [IDX_W-1:0]  class_id,
  output logic                     busy,
  output logic                     overrun
);

  localparam int N_W = IDX_W + 1;

  state_t                   r_state, w_next;
  logic        [WIN_W-1:0]  r_win;
  logic        [N_W-1:0]    r_n;
  logic        [ADDR_W-1:0] r_win_cnt;
  logic        [IDX_W-1:0]  r_k, r_arg, r_class_id;
  logic signed [ACC_W-1:0]  r_acc [NUM_OUT];
  logic signed [ACC_W-1:0]  r_max;
  logic                     r_overrun, r_class_valid;

  logic signed [DOT_W-1:0]  w_dot;
  logic signed [ACC_W-1:0]  w_cur;
  logic w_last_mac, w_last_win, w_beat, w_last_beat, w_acc_en, w_take_max;

  fc_dot9 u_dot (.i_a(r_win), .i_b(w_data), .o_dot(w_dot));

  // Result port handshake: a beat transfers on a cycle with res_valid && res_ready;
  // res_idx/res_data are held stable while res_valid is high and res_ready is low.
  assign w_last_mac  = (r_n == N_W'(NUM_OUT-1));
  assign w_last_win  = (r_win_cnt == ADDR_W'(NUM_WIN-1));
  assign w_beat      = (r_state == S_OUT) && res_ready;
  assign w_last_beat = w_beat && (r_k == IDX_W'(NUM_OUT-1));
  // Weight data lags its read by one cycle, so acc[n-1] is updated while n is issued.
  assign w_acc_en    = ((r_state == S_MAC) && (r_n != '0)) || (r_state == S_DRAIN);
  assign w_take_max  = (r_k == '0) || (w_cur > r_max);

  always_comb begin
    w_cur = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (r_k == IDX_W'(i)) w_cur = r_acc[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)       w_next = S_WAIT;
      S_WAIT:  if (fc_ready)    w_next = S_MAC;
      S_MAC:   if (w_last_mac)  w_next = S_DRAIN;
      S_DRAIN: w_next = w_last_win ? S_OUT : S_WAIT;
      S_OUT:   if (w_last_beat) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd      = 1'b0;
    w_addr    = '0;
    res_valid = 1'b0;
    res_idx   = '0;
    res_data  = '0;
    busy      = (r_state != S_IDLE);
    case (r_state)
      S_MAC: begin
        w_rd   = 1'b1;
        w_addr = ADDR_W'(r_win_cnt * NUM_OUT) + ADDR_W'(r_n);
      end
      S_OUT: begin
        res_valid = 1'b1;
        res_idx   = r_k;
        res_data  = w_cur;
      end
      default: ;
    endcase
  end

  assign class_valid = r_class_valid;
  assign class_id    = r_class_id;
  assign overrun     = r_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win         <= '0;
      r_n           <= '0;
      r_win_cnt     <= '0;
      r_k           <= '0;
      r_arg         <= '0;
      r_max         <= '0;
      r_overrun     <= 1'b0;
      r_class_valid <= 1'b0;
      r_class_id    <= '0;
      for (int i = 0; i < NUM_OUT; i++) r_acc[i] <= '0;
    end else begin
      r_class_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_win_cnt  <= '0;
          r_class_id <= '0;
          for (int i = 0; i < NUM_OUT; i++) r_acc[i] <= '0;
        end
        S_WAIT: if (fc_ready) begin
          r_win <= fc_data;
          r_n   <= '0;
        end
        S_MAC:   r_n <= r_n + 1'b1;
        S_DRAIN: begin
          r_win_cnt <= r_win_cnt + 1'b1;
          r_k       <= '0;
        end
        S_OUT: if (w_beat) begin
          if (w_take_max) begin
            r_max <= w_cur;
            r_arg <= r_k;
          end
          if (w_last_beat) begin
            r_class_valid <= 1'b1;
            r_class_id    <= w_take_max ? r_k : r_arg;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        default: ;
      endcase
      if (w_acc_en) begin
        for (int i = 0; i < NUM_OUT; i++) begin
          if (r_n == N_W'(i+1)) r_acc[i] <= r_acc[i] + {{(ACC_W-DOT_W){w_dot[DOT_W-1]}}, w_dot};
        end
      end
      // A start in IDLE clears the flag unless a window is dropped in that same cycle.
      if ((r_state == S_IDLE) && start) r_overrun <= fc_ready;
      else if (fc_ready && (r_state != S_WAIT)) r_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fc_layer_sched.sv
// Directed and randomized bench for fc_layer_sched with a weight ROM model and a
// dot-product reference computed directly from windows and weights.
module tb_fc_layer_sched;

  localparam int NUM_OUT = 3;
  localparam int NUM_WIN = 2;
  localparam int ACC_W   = 24;
  localparam int ADDR_W  = 8;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, fc_ready = 1'b0, res_ready = 1'b0;
  logic [71:0] fc_data = '0, w_data = '0;
  logic w_rd, res_valid, class_valid, busy, overrun;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0] res_idx, class_id;
  logic [ACC_W-1:0] res_data;

  always #5 clk = ~clk;

  fc_layer_sched #(.NUM_OUT(NUM_OUT), .NUM_WIN(NUM_WIN), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fc_ready(fc_ready), .fc_data(fc_data),
    .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx), .res_data(res_data),
    .class_valid(class_valid), .class_id(class_id), .busy(busy), .overrun(overrun)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [71:0] rom [256];
  logic [71:0] win_v [NUM_WIN];
  logic [ACC_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  int exp_class;
  logic pend_rd = 1'b0;
  logic [ADDR_W-1:0] pend_addr = '0;

  // Weight ROM: one-cycle read latency, random junk on the bus when no read is pending.
  always @(negedge clk) begin
    pend_rd   = w_rd;
    pend_addr = w_addr;
    if (w_rd) addr_q.push_back(w_addr);
  end

  always @(posedge clk) begin
    logic [95:0] junk;
    #1;
    junk   = {$urandom, $urandom, $urandom};
    w_data = pend_rd ? rom[pend_addr] : junk[71:0];
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] rep9(input logic [7:0] b);
    return {9{b}};
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_w_rd"}, w_rd, 0);
    chk({tag, "_w_addr"}, w_addr, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_idx"}, res_idx, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_class_valid"}, class_valid, 0);
    chk({tag, "_class_id"}, class_id, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  task automatic set_pattern(input logic [7:0] wb, input logic [7:0] n0, input logic [7:0] n1,
                             input logic [7:0] n2);
    for (int w = 0; w < NUM_WIN; w++) begin
      win_v[w] = rep9(wb);
      rom[w*NUM_OUT+0] = rep9(n0);
      rom[w*NUM_OUT+1] = rep9(n1);
      rom[w*NUM_OUT+2] = rep9(n2);
    end
  endtask

  task automatic set_random();
    logic [95:0] r;
    for (int w = 0; w < NUM_WIN; w++) begin
      r = {$urandom, $urandom, $urandom};
      win_v[w] = r[71:0];
      for (int j = 0; j < NUM_OUT; j++) begin
        r = {$urandom, $urandom, $urandom};
        rom[w*NUM_OUT+j] = r[71:0];
      end
    end
  endtask

  // Score j = sum over windows and lanes of window lane * weight lane, wrapped to ACC_W.
  task automatic build_expected();
    logic signed [ACC_W-1:0] sc [NUM_OUT];
    logic signed [7:0] a, b;
    longint t;
    exp_q.delete();
    for (int j = 0; j < NUM_OUT; j++) begin
      t = 0;
      for (int w = 0; w < NUM_WIN; w++) begin
        for (int l = 0; l < 9; l++) begin
          a = win_v[w][71-8*l -: 8];
          b = rom[w*NUM_OUT+j][71-8*l -: 8];
          t += a * b;
        end
      end
      sc[j] = t[ACC_W-1:0];
      exp_q.push_back(sc[j]);
    end
    exp_class = 0;
    for (int j = 1; j < NUM_OUT; j++) begin
      if (sc[j] > sc[exp_class]) exp_class = j;
    end
  endtask

  // mode: 0 clean, 1 extra window pulse during MAC of window 0, 2 fc_ready together with start.
  task automatic run_inf(input int mode, input bit bp, input bit rnd);
    logic [95:0] junk;
    logic [ACC_W-1:0] got_d;
    int beat, stall;
    bit done;
    build_expected();
    addr_q.delete();
    start = 1'b1;
    fc_ready = (mode == 2);
    fc_data = '1;
    tick();
    start = 1'b0;
    fc_ready = 1'b0;
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    chk("ovr_after_start", overrun, (mode == 2));
    tick();
    for (int w = 0; w < NUM_WIN; w++) begin
      if (rnd) repeat ($urandom_range(0, 2)) tick();
      fc_ready = 1'b1;
      fc_data  = win_v[w];
      tick();
      for (int c = 0; c <= NUM_OUT; c++) begin
        fc_ready = (mode == 1 && w == 0 && c == 1);
        junk = {$urandom, $urandom, $urandom};
        if (fc_ready) fc_data = junk[71:0];
        tick();
      end
      fc_ready = 1'b0;
    end
    beat = 0;
    stall = 0;
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      if (bp) res_ready = !(beat == 1 && stall < 5);
      else    res_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (c == 0) chk("out_entry_valid", res_valid, 1);
      if (class_valid) begin
        chk("class_id", class_id, exp_class);
        chk("class_after_last_beat", beat, NUM_OUT);
        done = 1'b1;
      end
      if (res_valid) begin
        if (beat < NUM_OUT) begin
          got_d = res_data;
          chk("res_idx", res_idx, beat);
          chk("res_data", got_d, exp_q[0]);
          if (res_ready) begin
            void'(exp_q.pop_front());
            beat++;
          end else if (beat == 1) begin
            stall++;
          end
        end else begin
          chk("extra_beat_valid", res_valid, 0);
        end
      end
      tick();
    end
    res_ready = 1'b0;
    chk("class_seen", done, 1);
    chk("ovr_end", overrun, (mode != 0));
    chk("addr_count", addr_q.size(), NUM_WIN*NUM_OUT);
    for (int i = 0; i < addr_q.size() && i < NUM_WIN*NUM_OUT; i++) chk("w_addr_seq", addr_q[i], i);
    @(negedge clk);
    chk("class_valid_one_pulse", class_valid, 0);
    chk("idle_res_valid", res_valid, 0);
    chk("idle_busy", busy, 0);
    chk("class_id_hold", class_id, exp_class);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    set_pattern(8'h01, 8'h01, 8'h01, 8'h01);
    run_inf(0, 1'b0, 1'b0);
    set_pattern(8'h80, 8'h7F, 8'h7F, 8'h7F);
    run_inf(0, 1'b0, 1'b0);
    set_pattern(8'h02, 8'h01, 8'hFF, 8'h03);
    run_inf(0, 1'b0, 1'b0);

    // Abort mid-MAC: everything returns to zero, then a fresh inference completes.
    start = 1'b1;
    tick();
    start = 1'b0;
    fc_ready = 1'b1;
    fc_data = win_v[0];
    tick();
    fc_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("abort");
    tick();
    rst_n = 1'b1;
    tick();
    run_inf(0, 1'b0, 1'b0);

    set_random();
    run_inf(1, 1'b0, 1'b0);
    run_inf(0, 1'b1, 1'b0);
    run_inf(2, 1'b0, 1'b1);
    for (int r = 0; r < 3; r++) begin
      set_random();
      run_inf(0, 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_layer_sched.md
Name: fc_layer_sched

Overview:
- Sequences the fully-connected layer that consumes the 9-sample window buffer (72-bit window, 9 signed 8-bit lanes, 1-cycle ready pulse).
- For each window, fetches one 72-bit weight word per output neuron from an external weight ROM and accumulates the 9-lane dot product into per-neuron accumulators.
- After NUM_WIN windows, streams the neuron scores out with a valid/ready handshake, then reports the argmax class.

Parameters:
- NUM_OUT, 10: output neurons (classes); minimum 2.
- NUM_WIN, 16: windows per inference.
- ACC_W, 24: accumulator and result width, signed.
- ADDR_W, 8: weight ROM address width; must satisfy 2^ADDR_W >= NUM_WIN*NUM_OUT.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin inference; honoured only in IDLE.
- fc_ready  in  1  window-valid pulse from the window buffer.
- fc_data  in  72  window; lane i = bits [71-8i -: 8], signed.
- w_rd  out  1  weight ROM read strobe.
- w_addr  out  ADDR_W  weight ROM address = win_cnt*NUM_OUT + n.
- w_data  in  72  weight word, lane order as fc_data, signed; valid exactly 1 cycle after w_rd.
- res_valid  out  1  score output valid.
- res_ready  in  1  score output accept.
- res_idx  out  4  neuron index of res_data.
- res_data  out  ACC_W  neuron score, signed.
- class_valid  out  1  1-cycle pulse; class_id valid.
- class_id  out  4  argmax neuron index.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky; a window arrived while not in WAIT_WIN.

Behaviour:
- Reset: state=IDLE; all outputs 0; accumulators, win_cnt, n and the window register cleared. Reset in any state aborts the operation immediately, with no partial output.
- IDLE: when start=1, clear all accumulators, win_cnt=0, overrun=0, then go to WAIT_WIN.
- WAIT_WIN: when fc_ready=1, latch fc_data into the window register, set n=0, then go to MAC.
- MAC, one cycle per neuron:
  - Assert w_rd with w_addr for neuron n, then increment n.
  - In the same cycle, w_data returned for neuron n-1 (if n>0) is multiplied lane-wise with the window and added to acc[n-1].
  - After issuing n=NUM_OUT-1, go to DRAIN.
- DRAIN: accumulate the last neuron, w_rd=0, increment win_cnt. If win_cnt was NUM_WIN-1, go to OUT with its index at 0; otherwise go to WAIT_WIN.
- Per-window timing: fc_ready at cycle 0, MAC in cycles 1..NUM_OUT, DRAIN in cycle NUM_OUT+1, next window accepted from cycle NUM_OUT+2.
- Arithmetic:
  - Each lane product is signed 8x8 -> 16 bits.
  - The 9-lane sum is 20-bit signed, sign-extended to ACC_W.
  - Accumulation wraps in two's complement; there is no saturation.
- OUT:
  - res_valid=1; res_idx=k; res_data=acc[k].
  - On res_valid&&res_ready, k increments. res_idx and res_data are held stable while res_ready=0.
  - A running max is updated on each accepted beat only when the score is strictly greater, so ties keep the lowest index.
  - After beat NUM_OUT-1 is accepted: res_valid=0, class_valid=1 for one cycle, class_id=argmax, then go to IDLE.
  - class_id holds until the next start.
- fc_ready in any state other than WAIT_WIN (including IDLE and DRAIN): the window is dropped and overrun is set. The sticky flag clears only on an accepted start or on reset.
- start outside IDLE is ignored.
- start and fc_ready in the same IDLE cycle: start is taken, fc_ready is dropped, and overrun is set.

Decomposition:
- Shared package holds:
  - State encoding localparams: S_IDLE, S_WAIT, S_MAC, S_DRAIN, S_OUT.
  - Lane constants: LANES=9, LANE_W=8, WIN_W=72.
- Sub-module fc_dot9: purely combinational signed 9-lane 8x8 dot product producing a 20-bit result, reusable by the conv path.

Test Plan (bench parameters NUM_OUT=3, NUM_WIN=2, ACC_W=24):
- Reset check: assert rst_n=0 during MAC -> next cycle all outputs 0, busy=0; then start with 2 windows -> normal result.
- Ones: all lanes of fc_data and every weight = 8'h01 -> scores 18,18,18; res_idx 0,1,2; class_id=0 (tie rule).
- Signed: fc_data lanes 8'h80, weights 8'h7F -> each window adds -146304 -> each score -292608 (24'hFB8900).
- Argmax: fc_data lanes 8'h02; weights for neurons 0/1/2 = 8'h01/8'hFF/8'h03 -> scores 36, -36, 108; class_id=2; w_addr sequence 0,1,2,3,4,5.
- Overrun: pulse fc_ready during MAC of window 0 -> overrun=1; scores identical to the run without the extra pulse; next start clears overrun.
- Backpressure: hold res_ready=0 for 5 cycles at beat 1 -> res_idx=1 and res_data stable; class_valid pulses exactly once, after beat 2 is accepted.
